// File: rtl/frame_release.sv
// frame_release: write-back half of the QA polled-driver frame reader.
// Every release_frame pulse queues one WrLine to the header line of the
// frame at the current release index, handing that frame back to the host.
// The shared QA types live in the package at the top of this file.

package qa_pkg;

  localparam int LOG_FRAME_BASE_POINTER = 25;
  localparam int LOG_FRAME_NUMBER       = 3;
  localparam int LOG_FRAME_CHUNKS       = 4;
  localparam int ADDR_W  = LOG_FRAME_BASE_POINTER + LOG_FRAME_NUMBER + LOG_FRAME_CHUNKS;
  localparam int MDATA_W = 16;
  localparam int DATA_W  = 512;

  typedef enum logic [3:0] {
    RT_NONE   = 4'h0,
    RT_WRLINE = 4'h2,
    RT_RDLINE = 4'h4
  } request_type_t;

  typedef struct packed {
    logic [5:0]         rsvd;
    request_type_t      request_type;
    logic [ADDR_W-1:0]  address;
    logic [MDATA_W-1:0] mdata;
  } header_t;

  typedef struct packed {
    logic request;
  } channel_req_t;

  typedef struct packed {
    channel_req_t      read;
    header_t           read_header;
    channel_req_t      write;
    header_t           write_header;
    logic [DATA_W-1:0] data;
  } frame_arb_t;

  typedef struct packed {
    logic reader_grant;
    logic writer_grant;
  } channel_grant_arb_t;

  typedef struct packed {
    logic        afu_en;
    logic [31:0] afu_ctl;
  } afu_csr_t;

endpackage

module frame_release
  import qa_pkg::*;
#(
  parameter int N_PENDING_BITS = LOG_FRAME_NUMBER + 1
) (
  input  logic                              clk,
  input  logic                              resetb,
  input  afu_csr_t                          csr,
  output frame_arb_t                        frame_reader,
  input  channel_grant_arb_t                write_grant,
  input  logic [LOG_FRAME_BASE_POINTER-1:0] frame_base_pointer,
  input  logic                              release_frame
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [N_PENDING_BITS-1:0]   pending_q, pending_d;
  logic [LOG_FRAME_NUMBER-1:0] release_frame_number_q, release_frame_number_d;

  logic write_request;
  logic grant_taken;

  // Only afu_en and writer_grant matter here; the rest is tied off.
  logic unused_inputs;
  assign unused_inputs = ^{csr.afu_ctl, write_grant.reader_grant};

  // The request is a pure function of the registered state.
  assign write_request = (state_q == S_REQ);
  assign grant_taken   = write_request && write_grant.writer_grant;

  // Next-state: outstanding count, release index and FSM state.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block can leave it unassigned and infer a latch.
    pending_d              = pending_q;
    release_frame_number_d = release_frame_number_q;
    state_d                = state_q;

    unique case ({release_frame, grant_taken})
      2'b10:   pending_d = pending_q + N_PENDING_BITS'(1);
      2'b01:   pending_d = pending_q - N_PENDING_BITS'(1);
      default: pending_d = pending_q;
    endcase

    // Same modulo-2^LOG_FRAME_NUMBER ring the reader walks.
    if (grant_taken) begin
      release_frame_number_d = release_frame_number_q + LOG_FRAME_NUMBER'(1);
    end

    // REQ exactly while something remains to be written back.
    state_d = (pending_d != '0) ? S_REQ : S_IDLE;

    // Disabling the AFU abandons any outstanding write-backs.
    if (!csr.afu_en) begin
      pending_d              = '0;
      release_frame_number_d = '0;
      state_d                = S_IDLE;
    end
  end

  // State register; async reset, afu_en acts as sync clear above.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q                <= S_IDLE;
      pending_q              <= '0;
      release_frame_number_q <= '0;
    end else begin
      state_q                <= state_d;
      pending_q              <= pending_d;
      release_frame_number_q <= release_frame_number_d;
    end
  end

  // Arbitration request: header line of the frame being released.
  always_comb begin
    frame_reader               = '0;
    frame_reader.write.request = write_request;
    if (write_request) begin
      frame_reader.write_header.request_type = RT_WRLINE;
      frame_reader.write_header.address      = {frame_base_pointer,
                                                release_frame_number_q,
                                                {LOG_FRAME_CHUNKS{1'b0}}};
    end
  end

endmodule

// File: tb/tb_frame_release.sv
// Bench for frame_release: a per-cycle vector table covers idle, single,
// stall, burst and simultaneous release/grant; hand sequences cover ring
// wrap and afu_en abort. Granted write addresses are scored against a queue
// filled as release pulses are driven.

module tb_frame_release;
  import qa_pkg::*;

  logic                              clk;
  logic                              resetb;
  afu_csr_t                          csr;
  frame_arb_t                        frame_reader;
  channel_grant_arb_t                write_grant;
  logic [LOG_FRAME_BASE_POINTER-1:0] frame_base_pointer;
  logic                              release_frame;

  frame_release dut (
    .clk                (clk),
    .resetb             (resetb),
    .csr                (csr),
    .frame_reader       (frame_reader),
    .write_grant        (write_grant),
    .frame_base_pointer (frame_base_pointer),
    .release_frame      (release_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic rel;
    logic gnt;
    logic exp_req;
  } vec_t;

  vec_t vecs[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [ADDR_W-1:0]           sb[$];
  logic [LOG_FRAME_NUMBER-1:0] rel_idx = '0;
  logic [ADDR_W-1:0]           last_addr = '0;
  int                          grant_count = 0;
  logic                        mon_en = 1'b0;

  logic    prev_req = 1'b0;
  logic    prev_gnt = 1'b0;
  logic    prev_en  = 1'b0;
  header_t prev_hdr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic en, input logic rel, input logic gnt, input logic exp_req);
    vecs.push_back('{en: en, rel: rel, gnt: gnt, exp_req: exp_req});
  endfunction

  // One clock: drive inputs just after posedge, return at negedge.
  task automatic cycle(input logic en, input logic rel, input logic gnt);
    @(posedge clk);
    #1;
    csr.afu_en               = en;
    release_frame            = rel;
    write_grant.writer_grant = gnt;
    if (!en) begin
      sb.delete();
      rel_idx = '0;
    end else if (rel) begin
      sb.push_back({frame_base_pointer, rel_idx, {LOG_FRAME_CHUNKS{1'b0}}});
      rel_idx = rel_idx + 1'b1;
    end
    @(negedge clk);
  endtask

  // Monitor: header contents, stability under stall, and granted writes.
  always @(negedge clk) begin
    if (mon_en) begin
      check("unused_fields_zero",
            64'(|{frame_reader.read.request, frame_reader.read_header, frame_reader.data}), 64'd0);
      if (!frame_reader.write.request) begin
        check("idle_hdr_zero", 64'(|frame_reader.write_header), 64'd0);
      end else begin
        check("hdr_type", 64'(frame_reader.write_header.request_type), 64'(RT_WRLINE));
        check("hdr_mdata_rsvd",
              64'(|{frame_reader.write_header.mdata, frame_reader.write_header.rsvd}), 64'd0);
        if (prev_req && !prev_gnt && prev_en) begin
          check("hdr_stable", 64'(frame_reader.write_header), 64'(prev_hdr));
        end
        if (write_grant.writer_grant) begin
          grant_count++;
          if (sb.size() == 0) begin
            check("sb_unexpected_write", 64'(frame_reader.write_header.address), 64'hdead);
          end else begin
            check("wr_addr", 64'(frame_reader.write_header.address), 64'(sb.pop_front()));
          end
          last_addr = frame_reader.write_header.address;
        end
      end
      prev_req = frame_reader.write.request;
      prev_gnt = write_grant.writer_grant;
      prev_en  = csr.afu_en;
      prev_hdr = frame_reader.write_header;
    end
  end

  initial begin
    // Idle after reset.
    for (int i = 0; i < 20; i++) add(1, 0, 0, 0);
    // Single release with grant tied high, twice.
    add(1, 1, 1, 0); add(1, 0, 1, 1); add(1, 0, 1, 0);
    add(1, 1, 1, 0); add(1, 0, 1, 1); add(1, 0, 1, 0);
    // Grant stall: 10 withheld cycles then granted.
    add(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 1);
    add(1, 0, 1, 1); add(1, 0, 1, 0);
    // Burst of three with grant withheld, then held high.
    add(1, 1, 0, 0); add(1, 1, 0, 1); add(1, 1, 0, 1);
    add(1, 0, 0, 1); add(1, 0, 0, 1);
    add(1, 0, 1, 1); add(1, 0, 1, 1); add(1, 0, 1, 1);
    add(1, 0, 1, 0); add(1, 0, 1, 0);
    // Release coinciding with a grant keeps the request up.
    add(1, 1, 0, 0); add(1, 0, 0, 1); add(1, 1, 1, 1);
    add(1, 0, 1, 1); add(1, 0, 1, 0); add(1, 0, 0, 0);

    resetb                   = 1'b0;
    csr                      = '0;
    csr.afu_en               = 1'b1;
    write_grant              = '0;
    release_frame            = 1'b0;
    frame_base_pointer       = 25'h5;

    repeat (3) @(negedge clk);
    check("rst_req", 64'(frame_reader.write.request), 64'd0);
    check("rst_hdr", 64'(|frame_reader.write_header), 64'd0);
    @(posedge clk);
    #1 resetb = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].en, vecs[i].rel, vecs[i].gnt);
      check($sformatf("req[%0d]", i), 64'(frame_reader.write.request), 64'(vecs[i].exp_req));
    end
    cycle(1, 0, 0);
    check("table_sb_drained", 64'(sb.size()), 64'd0);
    check("table_grant_total", 64'(grant_count), 64'd8);

    // Ring wrap: 2^LOG_FRAME_NUMBER+1 releases from a fresh start.
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    grant_count = 0;
    for (int i = 0; i < (1 << LOG_FRAME_NUMBER) + 1; i++) cycle(1, 1, 1);
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    check("wrap_req_idle", 64'(frame_reader.write.request), 64'd0);
    cycle(1, 0, 0);
    check("wrap_sb_drained", 64'(sb.size()), 64'd0);
    check("wrap_grants", 64'(grant_count), 64'((1 << LOG_FRAME_NUMBER) + 1));
    check("wrap_last_frame", 64'(last_addr[LOG_FRAME_CHUNKS +: LOG_FRAME_NUMBER]), 64'd0);

    // Abort mid-REQ, then restart on a different base.
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    check("abort_req_up", 64'(frame_reader.write.request), 64'd1);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("abort_req_drop", 64'(frame_reader.write.request), 64'd0);
    cycle(0, 0, 0);
    frame_base_pointer = 25'h1abc;
    cycle(1, 0, 0);
    cycle(1, 1, 1);
    cycle(1, 0, 1);
    check("restart_req", 64'(frame_reader.write.request), 64'd1);
    check("restart_addr", 64'(frame_reader.write_header.address),
          64'({25'h1abc, 3'd0, 4'd0}));
    cycle(1, 0, 0);
    check("restart_req_idle", 64'(frame_reader.write.request), 64'd0);
    check("restart_sb_drained", 64'(sb.size()), 64'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
